// File: rtl/vram_arbiter.sv
// vram_arbiter: PPU-priority arbiter for the single-port VRAM with a CPU starvation guard.
module vram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ppu_req,
  input  logic [12:0] ppu_addr,
  output logic        ppu_stall,
  output logic        ppu_rvalid,
  output logic [31:0] ppu_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [12:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [10:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_PPU  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  logic        cpu_busy_q, cpu_busy_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic        resp_we_q, resp_we_d;
  logic [31:0] ppu_rdata_q, ppu_rdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_pend, force_cpu, ppu_gnt, cpu_gnt;
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{ppu_addr[1:0], cpu_addr[1:0]};
  always_comb begin
    cpu_pend     = cpu_req & ~cpu_busy_q;
    force_cpu    = cpu_pend & (starve_cnt_q >= 4'(STARVE_MAX));
    // grants are gated by rst_n so the VRAM sees no access while reset is held
    ppu_gnt      = rst_n & ppu_req & ~force_cpu;
    cpu_gnt      = rst_n & cpu_pend & ~(ppu_req & ~force_cpu);
    ppu_stall    = ppu_req & force_cpu;
    mem_en       = ppu_gnt | cpu_gnt;
    mem_we       = cpu_gnt & cpu_we;
    mem_be       = mem_we ? cpu_be : 4'h0;
    mem_addr     = ppu_gnt ? ppu_addr[12:2] : cpu_addr[12:2];
    mem_wdata    = cpu_wdata;
    ppu_rvalid   = last_owner_q == OWN_PPU;
    cpu_ack      = last_owner_q == OWN_CPU;
    ppu_rdata    = ppu_rvalid ? mem_rdata : ppu_rdata_q;
    cpu_rdata    = (cpu_ack & ~resp_we_q) ? mem_rdata : cpu_rdata_q;
    ppu_rdata_d  = ppu_rdata;
    cpu_rdata_d  = cpu_rdata;
    starve_cnt_d = (cpu_gnt | ~cpu_pend) ? 4'd0 :
                   (ppu_gnt & (starve_cnt_q != 4'hF)) ? starve_cnt_q + 4'd1 : starve_cnt_q;
    cpu_busy_d   = cpu_gnt;
    last_owner_d = ppu_gnt ? OWN_PPU : cpu_gnt ? OWN_CPU : OWN_NONE;
    resp_we_d    = cpu_we;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_busy_q   <= 1'b0;
      starve_cnt_q <= 4'd0;
      last_owner_q <= OWN_NONE;
      resp_we_q    <= 1'b0;
      ppu_rdata_q  <= 32'h0;
      cpu_rdata_q  <= 32'h0;
    end else begin
      cpu_busy_q   <= cpu_busy_d;
      starve_cnt_q <= starve_cnt_d;
      last_owner_q <= last_owner_d;
      resp_we_q    <= resp_we_d;
      ppu_rdata_q  <= ppu_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end
endmodule
